if_stage: RTL and testbench

Instruction-fetch stage of the five-stage LA32R pipeline: the producer side of the `to_ds_valid` / `ds_allow_in` handshake consumed by the decode stage. It holds the fetch PC, issues requests to a synchronous instruction SRAM, and presents one `{pc, inst}` pair per cycle to decode. It redirects on `br_taken_cancel`/`br_target` and keeps the fetched word alive while decode stalls.

---
 rtl/if_stage.sv | 95 +++++++++
 tb/tb_if_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : LA32R instruction-fetch stage. Holds the fetch PC, issues
//               requests to a synchronous instruction SRAM and presents one
//               {pc, inst} pair per cycle to decode over the
//               to_ds_valid / ds_allow_in handshake. Redirects on
//               br_taken_cancel and keeps the fetched word alive across
//               decode stalls.
// Option      : IF_INST_BUF_EN - when defined, the fetched word is captured
//               into a local buffer on the first stall cycle and the SRAM is
//               left idle for the rest of the stall. When undefined, the
//               current PC is re-fetched every stall cycle instead.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allow_in,
    input  logic        br_taken_cancel,
    input  logic [31:0] br_target,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic        to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);

    // PC value held in reset so that the first sequential increment lands on RESET_PC
    localparam logic [31:0] C_RESET_PC_M4 = RESET_PC - 32'd4;

    logic        r_fs_valid;
    logic [31:0] r_fs_pc;
    logic        r_buf_valid;
    logic [31:0] r_inst_buf;

    logic        w_fs_allow_in;
    logic [31:0] w_nextpc;

    // Branch target low bits are ignored: fetch addresses are always word aligned
    logic        w_unused_tgt_lsb;
    assign w_unused_tgt_lsb = ^br_target[1:0];

    // A redirect overrides any stall: the held word is wrong-path and is discarded
    assign w_fs_allow_in = !r_fs_valid | ds_allow_in | br_taken_cancel;
    assign w_nextpc      = br_taken_cancel ? {br_target[31:2], 2'b00}
                                           : r_fs_pc + 32'd4;

`ifdef IF_INST_BUF_EN
    // SRAM is only touched when a new PC is being fetched; stalls are served from the buffer
    assign inst_sram_en   = w_fs_allow_in & !reset;
    assign inst_sram_addr = w_nextpc;

    // Capture the SRAM word on the first stall cycle; any advance invalidates it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_inst_buf  <= 32'h0;
        end else if (w_fs_allow_in) begin
            r_buf_valid <= 1'b0;
        end else if (r_fs_valid && !r_buf_valid && !ds_allow_in && !br_taken_cancel) begin
            r_buf_valid <= 1'b1;
            r_inst_buf  <= inst_sram_rdata;
        end
    end
`else
    // Without a buffer the current PC is replayed during stalls so rdata stays valid;
    // a request therefore issues on every cycle outside reset
    assign inst_sram_en   = (w_fs_allow_in | r_fs_valid) & !reset;
    assign inst_sram_addr = w_fs_allow_in ? w_nextpc : r_fs_pc;
    assign r_buf_valid    = 1'b0;
    assign r_inst_buf     = 32'h0;
`endif

    // Fetch PC / valid advance whenever the stage can accept a new instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fs_valid <= 1'b0;
            r_fs_pc    <= C_RESET_PC_M4;
        end else if (w_fs_allow_in) begin
            r_fs_valid <= 1'b1;
            r_fs_pc    <= w_nextpc;
        end
    end

    // The word behind a taken branch is squashed on the same cycle as the redirect
    assign to_ds_valid = r_fs_valid & !br_taken_cancel;
    assign fs_pc       = r_fs_pc;
    assign fs_inst     = r_buf_valid ? r_inst_buf : inst_sram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage with a synchronous
//               SRAM model whose contents are a fixed function of address.
//               The SRAM returns a poison word after an idle cycle so a
//               missing instruction buffer is visible.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ds_allow_in = 1'b0;
    logic        br_taken_cancel = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage #(.RESET_PC(32'h1c000000)) dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allow_in     (ds_allow_in),
        .br_taken_cancel (br_taken_cancel),
        .br_target       (br_target),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .to_ds_valid     (to_ds_valid),
        .fs_pc           (fs_pc),
        .fs_inst         (fs_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5a5a5a5a;
    endfunction

    // Synchronous SRAM model: data one cycle after request, poison when idle
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= word_of(inst_sram_addr);
        else              inst_sram_rdata <= 32'hdeadbeef;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ds_allow_in = 1'b1;
        repeat (2) next_cycle();
        n_checks++;
        if ({inst_sram_en, to_ds_valid, fs_pc} !== {1'b0, 1'b0, 32'h1bfffffc}) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b v=%b pc=%h, want en=0 v=0 pc=1bfffffc",
                     inst_sram_en, to_ds_valid, fs_pc);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({inst_sram_en, inst_sram_addr, to_ds_valid} !== {1'b1, 32'h1c000000, 1'b0}) begin
            n_fail++;
            $display("FAIL release_req: got en=%b addr=%h v=%b, want en=1 addr=1c000000 v=0",
                     inst_sram_en, inst_sram_addr, to_ds_valid);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] pc;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            pc = 32'h1c000000 + 32'(4 * i);
            n_checks++;
            if ({to_ds_valid, fs_pc, fs_inst, inst_sram_en, inst_sram_addr} !==
                {1'b1, pc, word_of(pc), 1'b1, pc + 32'd4}) begin
                n_fail++;
                $display("FAIL seq_%0d: got v=%b pc=%h inst=%h en=%b addr=%h, want v=1 pc=%h inst=%h en=1 addr=%h",
                         i, to_ds_valid, fs_pc, fs_inst, inst_sram_en, inst_sram_addr,
                         pc, word_of(pc), pc + 32'd4);
            end
        end
    endtask

    task automatic test_stall();
        ds_allow_in = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({to_ds_valid, fs_pc, fs_inst} !== {1'b1, 32'h1c000008, word_of(32'h1c000008)}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got v=%b pc=%h inst=%h, want v=1 pc=1c000008 inst=%h",
                         i, to_ds_valid, fs_pc, fs_inst, word_of(32'h1c000008));
            end
`ifdef IF_INST_BUF_EN
            if (i > 0) begin
                n_checks++;
                if (inst_sram_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_idle_%0d: got en=%b, want en=0", i, inst_sram_en);
                end
            end
`else
            n_checks++;
            if ({inst_sram_en, inst_sram_addr} !== {1'b1, 32'h1c000008}) begin
                n_fail++;
                $display("FAIL stall_replay_%0d: got en=%b addr=%h, want en=1 addr=1c000008",
                         i, inst_sram_en, inst_sram_addr);
            end
`endif
            next_cycle();
        end
        ds_allow_in = 1'b1;
        #1;
        n_checks++;
        if ({to_ds_valid, fs_pc, fs_inst, inst_sram_en, inst_sram_addr} !==
            {1'b1, 32'h1c000008, word_of(32'h1c000008), 1'b1, 32'h1c00000c}) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b pc=%h inst=%h en=%b addr=%h, want pc=1c000008 addr=1c00000c",
                     to_ds_valid, fs_pc, fs_inst, inst_sram_en, inst_sram_addr);
        end
        for (int i = 0; i < 2; i++) begin
            logic [31:0] pc;
            next_cycle();
            pc = 32'h1c00000c + 32'(4 * i);
            n_checks++;
            if ({to_ds_valid, fs_pc, fs_inst} !== {1'b1, pc, word_of(pc)}) begin
                n_fail++;
                $display("FAIL after_stall_%0d: got v=%b pc=%h inst=%h, want pc=%h inst=%h",
                         i, to_ds_valid, fs_pc, fs_inst, pc, word_of(pc));
            end
        end
    endtask

    task automatic test_branch();
        br_taken_cancel = 1'b1;
        br_target = 32'h1c000100;
        #1;
        n_checks++;
        if ({to_ds_valid, inst_sram_en, inst_sram_addr} !== {1'b0, 1'b1, 32'h1c000100}) begin
            n_fail++;
            $display("FAIL branch_req: got v=%b en=%b addr=%h, want v=0 en=1 addr=1c000100",
                     to_ds_valid, inst_sram_en, inst_sram_addr);
        end
        next_cycle();
        br_taken_cancel = 1'b0;
        #1;
        n_checks++;
        if ({to_ds_valid, fs_pc, fs_inst, inst_sram_addr} !==
            {1'b1, 32'h1c000100, word_of(32'h1c000100), 32'h1c000104}) begin
            n_fail++;
            $display("FAIL branch_target: got v=%b pc=%h inst=%h addr=%h, want pc=1c000100 inst=%h addr=1c000104",
                     to_ds_valid, fs_pc, fs_inst, inst_sram_addr, word_of(32'h1c000100));
        end
    endtask

    task automatic test_cancel_in_stall();
        ds_allow_in = 1'b0;
        #1;
        n_checks++;
        if ({to_ds_valid, fs_pc, fs_inst} !== {1'b1, 32'h1c000100, word_of(32'h1c000100)}) begin
            n_fail++;
            $display("FAIL cstall_hold: got v=%b pc=%h inst=%h, want pc=1c000100 inst=%h",
                     to_ds_valid, fs_pc, fs_inst, word_of(32'h1c000100));
        end
        next_cycle();
        br_taken_cancel = 1'b1;
        br_target = 32'h1c000203;
        #1;
        n_checks++;
        if ({to_ds_valid, inst_sram_en, inst_sram_addr} !== {1'b0, 1'b1, 32'h1c000200}) begin
            n_fail++;
            $display("FAIL cstall_req: got v=%b en=%b addr=%h, want v=0 en=1 addr=1c000200",
                     to_ds_valid, inst_sram_en, inst_sram_addr);
        end
        next_cycle();
        br_taken_cancel = 1'b0;
        ds_allow_in = 1'b1;
        #1;
        n_checks++;
        if ({to_ds_valid, fs_pc, fs_inst} !== {1'b1, 32'h1c000200, word_of(32'h1c000200)}) begin
            n_fail++;
            $display("FAIL cstall_target: got v=%b pc=%h inst=%h, want pc=1c000200 inst=%h",
                     to_ds_valid, fs_pc, fs_inst, word_of(32'h1c000200));
        end
    endtask

    task automatic test_async_reset();
        ds_allow_in = 1'b0;
        next_cycle();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({to_ds_valid, inst_sram_en, fs_pc} !== {1'b0, 1'b0, 32'h1bfffffc}) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b en=%b pc=%h, want v=0 en=0 pc=1bfffffc",
                     to_ds_valid, inst_sram_en, fs_pc);
        end
        next_cycle();
        reset = 1'b0;
        ds_allow_in = 1'b1;
        #1;
        n_checks++;
        if ({inst_sram_en, inst_sram_addr} !== {1'b1, 32'h1c000000}) begin
            n_fail++;
            $display("FAIL restart_req: got en=%b addr=%h, want en=1 addr=1c000000",
                     inst_sram_en, inst_sram_addr);
        end
        next_cycle();
        n_checks++;
        if ({to_ds_valid, fs_pc, fs_inst} !== {1'b1, 32'h1c000000, word_of(32'h1c000000)}) begin
            n_fail++;
            $display("FAIL restart_present: got v=%b pc=%h inst=%h, want pc=1c000000 inst=%h",
                     to_ds_valid, fs_pc, fs_inst, word_of(32'h1c000000));
        end
    endtask

    task automatic test_wrap();
        br_taken_cancel = 1'b1;
        br_target = 32'hffffffff;
        #1;
        n_checks++;
        if (inst_sram_addr !== 32'hfffffffc) begin
            n_fail++;
            $display("FAIL wrap_align: got addr=%h, want fffffffc", inst_sram_addr);
        end
        next_cycle();
        br_taken_cancel = 1'b0;
        #1;
        n_checks++;
        if ({to_ds_valid, fs_pc, inst_sram_en, inst_sram_addr} !==
            {1'b1, 32'hfffffffc, 1'b1, 32'h00000000}) begin
            n_fail++;
            $display("FAIL wrap_req: got v=%b pc=%h en=%b addr=%h, want v=1 pc=fffffffc en=1 addr=00000000",
                     to_ds_valid, fs_pc, inst_sram_en, inst_sram_addr);
        end
        next_cycle();
        n_checks++;
        if ({to_ds_valid, fs_pc, fs_inst} !== {1'b1, 32'h00000000, word_of(32'h00000000)}) begin
            n_fail++;
            $display("FAIL wrap_present: got v=%b pc=%h inst=%h, want pc=00000000 inst=%h",
                     to_ds_valid, fs_pc, fs_inst, word_of(32'h00000000));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_cancel_in_stall();
        test_async_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
